// File: rtl/shapool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shapool_ctrl
// Description : Job-control FSM for the SHA pool (IDLE/LOAD/EXEC/DONE) driven
//               by the global and daisy SPI chip selects.
// Revision    : 1.0 - initial release
// ============================================================================
module shapool_ctrl #(
    parameter int LED_DIV_LOG2 = 22
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic       cs0_n_sync_in,
    input  logic       cs1_n_sync_in,
    input  logic       pool_success_in,
    input  logic       pool_exhausted_in,
    output logic       core_reset_out,
    output logic       core_enable_out,
    output logic       result_capture_out,
    output logic       ready_out,
    output logic       status_led_n_out,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_EXEC = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [LED_DIV_LOG2-1:0] c_blink_one = LED_DIV_LOG2'(1);

    state_t                  r_state;
    logic                    r_success;
    logic [LED_DIV_LOG2-1:0] r_blink;
    logic                    r_cs0_prev;
    logic                    r_cs1_prev;

    state_t                  w_state_next;
    logic                    w_success_next;
    logic                    w_capture_next;
    logic [LED_DIV_LOG2-1:0] w_blink_next;
    logic                    w_led_n_next;
    logic                    w_cs0_fall;
    logic                    w_cs0_rise;
    logic                    w_cs1_rise;

    assign w_cs0_fall = r_cs0_prev & ~cs0_n_sync_in;
    assign w_cs0_rise = ~r_cs0_prev & cs0_n_sync_in;
    assign w_cs1_rise = ~r_cs1_prev & cs1_n_sync_in;

    always_comb begin
        w_state_next   = r_state;
        w_success_next = r_success;
        w_capture_next = 1'b0;
        case (r_state)
            S_IDLE: if (w_cs0_fall) w_state_next = S_LOAD;
            S_LOAD: if (w_cs0_rise) w_state_next = S_EXEC;
            S_EXEC: begin
                // Preemption by a new job beats any pool result this cycle.
                if (w_cs0_fall) begin
                    w_state_next = S_LOAD;
                end else if (pool_success_in) begin
                    w_state_next   = S_DONE;
                    w_success_next = 1'b1;
                    w_capture_next = 1'b1;
                end else if (pool_exhausted_in) begin
                    w_state_next   = S_DONE;
                    w_success_next = 1'b0;
                    w_capture_next = 1'b1;
                end
            end
            S_DONE: begin
                if (w_cs0_fall)      w_state_next = S_LOAD;
                else if (w_cs1_rise) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        if ((w_state_next == S_IDLE) || (w_state_next == S_LOAD)) begin
            w_success_next = 1'b0;
        end
    end

    always_comb begin
        w_blink_next = '0;
        if (w_state_next == S_EXEC && r_state == S_EXEC) begin
            w_blink_next = r_blink + c_blink_one;
        end
    end

    // LED is computed from next-state values so it lines up with state_out.
    always_comb begin
        w_led_n_next = 1'b1;
        case (w_state_next)
            S_IDLE:  w_led_n_next = 1'b1;
            S_LOAD:  w_led_n_next = 1'b0;
            S_EXEC:  w_led_n_next = ~w_blink_next[LED_DIV_LOG2-1];
            S_DONE:  w_led_n_next = ~w_success_next;
            default: w_led_n_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state            <= S_IDLE;
            r_success          <= 1'b0;
            r_blink            <= '0;
            r_cs0_prev         <= 1'b1;
            r_cs1_prev         <= 1'b1;
            core_reset_out     <= 1'b1;
            core_enable_out    <= 1'b0;
            result_capture_out <= 1'b0;
            ready_out          <= 1'b0;
            status_led_n_out   <= 1'b1;
            state_out          <= 2'd0;
        end else begin
            r_state            <= w_state_next;
            r_success          <= w_success_next;
            r_blink            <= w_blink_next;
            r_cs0_prev         <= cs0_n_sync_in;
            r_cs1_prev         <= cs1_n_sync_in;
            core_reset_out     <= (w_state_next == S_IDLE) || (w_state_next == S_LOAD);
            core_enable_out    <= (w_state_next == S_EXEC);
            result_capture_out <= w_capture_next;
            ready_out          <= w_success_next;
            status_led_n_out   <= w_led_n_next;
            state_out          <= w_state_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shapool_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_shapool_ctrl
// Description : Directed and randomized self-checking bench for shapool_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shapool_ctrl;

    localparam int N = 4;

    logic       clk_in            = 1'b0;
    logic       reset_in          = 1'b1;
    logic       cs0_n_sync_in     = 1'b1;
    logic       cs1_n_sync_in     = 1'b1;
    logic       pool_success_in   = 1'b0;
    logic       pool_exhausted_in = 1'b0;
    logic       core_reset_out;
    logic       core_enable_out;
    logic       result_capture_out;
    logic       ready_out;
    logic       status_led_n_out;
    logic [1:0] state_out;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    shapool_ctrl #(.LED_DIV_LOG2(N)) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .cs0_n_sync_in     (cs0_n_sync_in),
        .cs1_n_sync_in     (cs1_n_sync_in),
        .pool_success_in   (pool_success_in),
        .pool_exhausted_in (pool_exhausted_in),
        .core_reset_out    (core_reset_out),
        .core_enable_out   (core_enable_out),
        .result_capture_out(result_capture_out),
        .ready_out         (ready_out),
        .status_led_n_out  (status_led_n_out),
        .state_out         (state_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk_in);
    endtask

    // Behavioural model: state as a small integer, time spent in EXEC as an
    // unbounded cycle count, blink derived by division.
    int m_state  = 0;
    bit m_succ   = 0;
    bit m_cap    = 0;
    bit m_p0     = 1;
    bit m_p1     = 1;
    int m_exec   = 0;
    bit m_valid  = 0;
    bit m_f0, m_r0, m_r1;

    always @(posedge clk_in) begin
        if (reset_in) begin
            m_state = 0; m_succ = 0; m_cap = 0; m_p0 = 1; m_p1 = 1; m_exec = 0;
            m_valid = 1;
        end else begin
            m_f0  = m_p0 && !cs0_n_sync_in;
            m_r0  = !m_p0 && cs0_n_sync_in;
            m_r1  = !m_p1 && cs1_n_sync_in;
            m_cap = 0;
            case (m_state)
                0: if (m_f0) m_state = 1;
                1: if (m_r0) begin m_state = 2; m_exec = 0; end
                2: begin
                    if (m_f0) begin m_state = 1; m_succ = 0; end
                    else if (pool_success_in) begin m_state = 3; m_succ = 1; m_cap = 1; end
                    else if (pool_exhausted_in) begin m_state = 3; m_succ = 0; m_cap = 1; end
                    else m_exec++;
                end
                default: begin
                    if (m_f0) begin m_state = 1; m_succ = 0; end
                    else if (m_r1) begin m_state = 0; m_succ = 0; end
                end
            endcase
            m_p0 = cs0_n_sync_in;
            m_p1 = cs1_n_sync_in;
        end
    end

    function automatic logic exp_led();
        case (m_state)
            0:       return 1'b1;
            1:       return 1'b0;
            2:       return ((m_exec / (1 << (N - 1))) % 2) == 0;
            default: return !m_succ;
        endcase
    endfunction

    always @(posedge clk_in) begin
        #1;
        if (m_valid) begin
            check("state_out",          32'(state_out),          32'(m_state));
            check("core_reset_out",     32'(core_reset_out),     32'(m_state < 2));
            check("core_enable_out",    32'(core_enable_out),    32'(m_state == 2));
            check("result_capture_out", 32'(result_capture_out), 32'(m_cap));
            check("ready_out",          32'(ready_out),          32'(m_succ));
            check("status_led_n_out",   32'(status_led_n_out),   32'(exp_led()));
        end
    end

    initial begin
        tick(2);
        reset_in = 1'b0;
        check("lit_reset_state", 32'(state_out), 0);
        check("lit_reset_core_reset", 32'(core_reset_out), 1);
        check("lit_reset_led", 32'(status_led_n_out), 1);

        // Job load then start: IDLE -> LOAD -> EXEC
        cs0_n_sync_in = 1'b0; tick();
        check("lit_load_state", 32'(state_out), 1);
        check("lit_load_led", 32'(status_led_n_out), 0);
        tick(9);
        cs0_n_sync_in = 1'b1; tick();
        check("lit_exec_state", 32'(state_out), 2);
        check("lit_exec_core_reset", 32'(core_reset_out), 0);
        check("lit_exec_enable", 32'(core_enable_out), 1);
        check("lit_blink_k0", 32'(status_led_n_out), 1);
        tick(7);
        check("lit_blink_k7", 32'(status_led_n_out), 1);
        tick();
        check("lit_blink_k8", 32'(status_led_n_out), 0);
        tick(8);
        check("lit_blink_k16", 32'(status_led_n_out), 1);
        tick(4);

        // Success at cycle 20 of EXEC
        pool_success_in = 1'b1; tick();
        pool_success_in = 1'b0;
        check("lit_done_state", 32'(state_out), 3);
        check("lit_done_capture", 32'(result_capture_out), 1);
        check("lit_done_ready", 32'(ready_out), 1);
        check("lit_done_led", 32'(status_led_n_out), 0);
        tick();
        check("lit_capture_once", 32'(result_capture_out), 0);
        cs1_n_sync_in = 1'b0; tick();
        check("lit_cs1_low_done", 32'(state_out), 3);
        cs1_n_sync_in = 1'b1; tick();
        check("lit_readout_idle", 32'(state_out), 0);
        check("lit_readout_ready", 32'(ready_out), 0);

        // Exhausted alone
        cs0_n_sync_in = 1'b0; tick(3);
        cs0_n_sync_in = 1'b1; tick(3);
        pool_exhausted_in = 1'b1; tick();
        pool_exhausted_in = 1'b0;
        check("lit_exh_state", 32'(state_out), 3);
        check("lit_exh_ready", 32'(ready_out), 0);
        check("lit_exh_led", 32'(status_led_n_out), 1);

        // Restart from DONE, then success and exhausted together
        cs0_n_sync_in = 1'b0; tick();
        check("lit_done_to_load", 32'(state_out), 1);
        cs0_n_sync_in = 1'b1; tick(2);
        pool_success_in = 1'b1; pool_exhausted_in = 1'b1; tick();
        pool_success_in = 1'b0; pool_exhausted_in = 1'b0;
        check("lit_both_ready", 32'(ready_out), 1);

        // Preemption coincident with success
        cs0_n_sync_in = 1'b0; tick();
        cs0_n_sync_in = 1'b1; tick(2);
        cs0_n_sync_in = 1'b0; pool_success_in = 1'b1; tick();
        pool_success_in = 1'b0;
        check("lit_preempt_state", 32'(state_out), 1);
        check("lit_preempt_capture", 32'(result_capture_out), 0);
        check("lit_preempt_ready", 32'(ready_out), 0);

        // Reset mid-EXEC, then cs1 activity in IDLE
        cs0_n_sync_in = 1'b1; tick(3);
        reset_in = 1'b1; tick();
        reset_in = 1'b0;
        check("lit_rst_state", 32'(state_out), 0);
        check("lit_rst_enable", 32'(core_enable_out), 0);
        check("lit_rst_capture", 32'(result_capture_out), 0);
        cs1_n_sync_in = 1'b0; tick();
        cs1_n_sync_in = 1'b1; tick();
        check("lit_idle_cs1", 32'(state_out), 0);

        // Randomized phase, checked by the model every cycle
        for (int i = 0; i < 4000; i++) begin
            reset_in          = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 24) == 0) cs0_n_sync_in = ~cs0_n_sync_in;
            if ($urandom_range(0, 5) == 0)  cs1_n_sync_in = ~cs1_n_sync_in;
            pool_success_in   = ($urandom_range(0, 39) == 0);
            pool_exhausted_in = ($urandom_range(0, 49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
